mem_access: RTL and testbench

Memory-access pipeline stage between execute and `writeback`. Takes one instruction per handshake from execute and runs loads and stores over a request/acknowledge data-memory port. It generates byte strobes and replicated write data for stores. It registers the word-wide read data, `funct3`, address index and ALU result that `writeback` needs to select and extend the final register value.

---
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_access.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_access.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge port shared by the memory-access stage and its memory.
interface mem_access_if #(
    parameter int unsigned CPU_WIDTH = 32
);
    logic                 dmem_req;
    logic                 dmem_we;
    logic [CPU_WIDTH-1:0] dmem_addr;
    logic [3:0]           dmem_wstrb;
    logic [CPU_WIDTH-1:0] dmem_wdata;
    logic                 dmem_ack;
    logic [CPU_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs loads/stores over the dmem port and
// registers the fields writeback needs to select and extend the result.
module mem_access #(
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned CPU_WIDTH    = 32,
    parameter int unsigned FUNCT3_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid_i,
    output logic                    ready_o,
    input  logic                    ex_is_load_i,
    input  logic                    ex_is_store_i,
    input  logic [FUNCT3_WIDTH-1:0] ex_funct3_i,
    input  logic [CPU_WIDTH-1:0]    ex_alu_result_i,
    input  logic [CPU_WIDTH-1:0]    ex_store_data_i,
    input  logic [4:0]              ex_rd_i,
    input  logic                    ex_reg_wr_en_i,
    mem_access_if.master            dmem,
    output logic                    wb_valid_o,
    output logic [CPU_WIDTH-1:0]    wb_reg_wr_data_o,
    output logic                    no_writing_mem_o,
    output logic [CPU_WIDTH-1:0]    data_mem_data_o,
    output logic [FUNCT3_WIDTH-1:0] funct3_o,
    output logic [1:0]              mem_addr_index_o,
    output logic [4:0]              rd_o,
    output logic                    reg_wr_en_o,
    output logic                    addr_err_o,
    output logic                    bus_err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUS  = 1'b1;

    logic [0:0]              state, state_n;
    logic [CNT_W-1:0]        count, count_n;

    // Instruction fields held while the bus access is outstanding
    logic                    pend_load, pend_load_n;
    logic                    pend_wr_en, pend_wr_en_n;
    logic [4:0]              pend_rd, pend_rd_n;
    logic [FUNCT3_WIDTH-1:0] pend_f3, pend_f3_n;
    logic [1:0]              pend_idx, pend_idx_n;
    logic [CPU_WIDTH-1:0]    pend_alu, pend_alu_n;

    logic                    req_n, we_n;
    logic [CPU_WIDTH-1:0]    addr_n, wdata_n;
    logic [3:0]              wstrb_n;

    logic                    wb_valid_n, nwm_n, reg_wr_en_n, addr_err_n, bus_err_n;
    logic [CPU_WIDTH-1:0]    wb_data_n, mem_data_n;
    logic [FUNCT3_WIDTH-1:0] f3_out_n;
    logic [1:0]              idx_out_n;
    logic [4:0]              rd_out_n;

    logic [2:0]              f3;
    logic [1:0]              idx;
    logic                    is_mem, f3_ok, align_ok, legal;
    logic [3:0]              st_strb;
    logic [CPU_WIDTH-1:0]    st_data;

    assign ready_o = (state == IDLE);
    assign f3      = 3'(ex_funct3_i);
    assign idx     = ex_alu_result_i[1:0];
    assign is_mem  = ex_is_load_i | ex_is_store_i;

    // Legality of width code and alignment, plus store lane/data generation
    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        st_strb  = 4'b0000;
        st_data  = ex_store_data_i;
        if (ex_is_load_i && !ex_is_store_i) begin
            f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        end else if (ex_is_store_i && !ex_is_load_i) begin
            f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end
        case (f3[1:0])
            2'b01:   align_ok = !idx[0];
            2'b10:   align_ok = (idx == 2'b00);
            default: align_ok = 1'b1;
        endcase
        case (f3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << idx;
                st_data = CPU_WIDTH'({4{ex_store_data_i[7:0]}});
            end
            2'b01: begin
                st_strb = idx[1] ? 4'b1100 : 4'b0011;
                st_data = CPU_WIDTH'({2{ex_store_data_i[15:0]}});
            end
            default: begin
                st_strb = 4'b1111;
                st_data = ex_store_data_i;
            end
        endcase
        legal = is_mem && f3_ok && align_ok;
    end

    // Next-state and next-output logic
    always_comb begin
        state_n      = state;
        count_n      = count;
        pend_load_n  = pend_load;
        pend_wr_en_n = pend_wr_en;
        pend_rd_n    = pend_rd;
        pend_f3_n    = pend_f3;
        pend_idx_n   = pend_idx;
        pend_alu_n   = pend_alu;
        req_n        = dmem.dmem_req;
        we_n         = dmem.dmem_we;
        addr_n       = dmem.dmem_addr;
        wstrb_n      = dmem.dmem_wstrb;
        wdata_n      = dmem.dmem_wdata;
        wb_valid_n   = 1'b0;
        addr_err_n   = 1'b0;
        bus_err_n    = 1'b0;
        nwm_n        = no_writing_mem_o;
        reg_wr_en_n  = reg_wr_en_o;
        wb_data_n    = wb_reg_wr_data_o;
        mem_data_n   = data_mem_data_o;
        f3_out_n     = funct3_o;
        idx_out_n    = mem_addr_index_o;
        rd_out_n     = rd_o;

        case (state)
            IDLE: begin
                if (ex_valid_i) begin
                    if (!is_mem || !legal) begin
                        wb_valid_n  = 1'b1;
                        wb_data_n   = ex_alu_result_i;
                        nwm_n       = 1'b0;
                        reg_wr_en_n = is_mem ? 1'b0 : ex_reg_wr_en_i;
                        addr_err_n  = is_mem;
                        f3_out_n    = ex_funct3_i;
                        idx_out_n   = idx;
                        rd_out_n    = ex_rd_i;
                    end else begin
                        state_n      = BUS;
                        count_n      = '0;
                        req_n        = 1'b1;
                        we_n         = ex_is_store_i;
                        addr_n       = {ex_alu_result_i[CPU_WIDTH-1:2], 2'b00};
                        wstrb_n      = ex_is_store_i ? st_strb : 4'b0000;
                        wdata_n      = st_data;
                        pend_load_n  = ex_is_load_i;
                        pend_wr_en_n = ex_reg_wr_en_i;
                        pend_rd_n    = ex_rd_i;
                        pend_f3_n    = ex_funct3_i;
                        pend_idx_n   = idx;
                        pend_alu_n   = ex_alu_result_i;
                    end
                end
            end
            BUS: begin
                if (dmem.dmem_ack || (count == CNT_W'(TIMEOUT - 1))) begin
                    state_n    = IDLE;
                    req_n      = 1'b0;
                    we_n       = 1'b0;
                    wb_valid_n = 1'b1;
                    wb_data_n  = pend_alu;
                    f3_out_n   = pend_f3;
                    idx_out_n  = pend_idx;
                    rd_out_n   = pend_rd;
                    if (dmem.dmem_ack && pend_load) begin
                        mem_data_n  = dmem.dmem_rdata;
                        nwm_n       = 1'b1;
                        reg_wr_en_n = pend_wr_en;
                    end else begin
                        nwm_n       = 1'b0;
                        reg_wr_en_n = 1'b0;
                    end
                    bus_err_n = !dmem.dmem_ack;
                end else begin
                    count_n = count + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            count            <= '0;
            pend_load        <= 1'b0;
            pend_wr_en       <= 1'b0;
            pend_rd          <= '0;
            pend_f3          <= '0;
            pend_idx         <= '0;
            pend_alu         <= '0;
            dmem.dmem_req    <= 1'b0;
            dmem.dmem_we     <= 1'b0;
            dmem.dmem_addr   <= '0;
            dmem.dmem_wstrb  <= '0;
            dmem.dmem_wdata  <= '0;
            wb_valid_o       <= 1'b0;
            wb_reg_wr_data_o <= '0;
            no_writing_mem_o <= 1'b0;
            data_mem_data_o  <= '0;
            funct3_o         <= '0;
            mem_addr_index_o <= '0;
            rd_o             <= '0;
            reg_wr_en_o      <= 1'b0;
            addr_err_o       <= 1'b0;
            bus_err_o        <= 1'b0;
        end else begin
            state            <= state_n;
            count            <= count_n;
            pend_load        <= pend_load_n;
            pend_wr_en       <= pend_wr_en_n;
            pend_rd          <= pend_rd_n;
            pend_f3          <= pend_f3_n;
            pend_idx         <= pend_idx_n;
            pend_alu         <= pend_alu_n;
            dmem.dmem_req    <= req_n;
            dmem.dmem_we     <= we_n;
            dmem.dmem_addr   <= addr_n;
            dmem.dmem_wstrb  <= wstrb_n;
            dmem.dmem_wdata  <= wdata_n;
            wb_valid_o       <= wb_valid_n;
            wb_reg_wr_data_o <= wb_data_n;
            no_writing_mem_o <= nwm_n;
            data_mem_data_o  <= mem_data_n;
            funct3_o         <= f3_out_n;
            mem_addr_index_o <= idx_out_n;
            rd_o             <= rd_out_n;
            reg_wr_en_o      <= reg_wr_en_n;
            addr_err_o       <= addr_err_n;
            bus_err_o        <= bus_err_n;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected writeback
// records, a negedge monitor pops and compares on every wb_valid_o pulse.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ready;
    logic        ex_is_load = 1'b0;
    logic        ex_is_store = 1'b0;
    logic [2:0]  ex_funct3 = 3'b000;
    logic [31:0] ex_alu_result = 32'h0;
    logic [31:0] ex_store_data = 32'h0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_reg_wr_en = 1'b0;
    logic        wb_valid;
    logic [31:0] wb_reg_wr_data;
    logic        no_writing_mem;
    logic [31:0] data_mem_data;
    logic [2:0]  funct3;
    logic [1:0]  mem_addr_index;
    logic [4:0]  rd;
    logic        reg_wr_en;
    logic        addr_err;
    logic        bus_err;

    mem_access_if #(.CPU_WIDTH(32)) bus ();

    mem_access #(.TIMEOUT(16), .CPU_WIDTH(32), .FUNCT3_WIDTH(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid_i       (ex_valid),
        .ready_o          (ready),
        .ex_is_load_i     (ex_is_load),
        .ex_is_store_i    (ex_is_store),
        .ex_funct3_i      (ex_funct3),
        .ex_alu_result_i  (ex_alu_result),
        .ex_store_data_i  (ex_store_data),
        .ex_rd_i          (ex_rd),
        .ex_reg_wr_en_i   (ex_reg_wr_en),
        .dmem             (bus),
        .wb_valid_o       (wb_valid),
        .wb_reg_wr_data_o (wb_reg_wr_data),
        .no_writing_mem_o (no_writing_mem),
        .data_mem_data_o  (data_mem_data),
        .funct3_o         (funct3),
        .mem_addr_index_o (mem_addr_index),
        .rd_o             (rd),
        .reg_wr_en_o      (reg_wr_en),
        .addr_err_o       (addr_err),
        .bus_err_o        (bus_err)
    );

    typedef struct {
        logic [31:0] wb_data;
        logic        nwm;
        logic [31:0] mem_data;
        logic [2:0]  f3;
        logic [1:0]  idx;
        logic [4:0]  rd;
        logic        wen;
        logic        aerr;
        logic        berr;
        int          at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] model_data = 32'h0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every writeback pulse must match the oldest expected record
    always @(negedge clk) begin
        if (wb_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb actual=1 required=0 cycle=%0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_cycle",    32'(cyc),            32'(mon_e.at));
                chk("wb_data",     wb_reg_wr_data,      mon_e.wb_data);
                chk("no_wr_mem",   32'(no_writing_mem), 32'(mon_e.nwm));
                chk("mem_data",    data_mem_data,       mon_e.mem_data);
                chk("funct3",      32'(funct3),         32'(mon_e.f3));
                chk("addr_index",  32'(mem_addr_index), 32'(mon_e.idx));
                chk("rd",          32'(rd),             32'(mon_e.rd));
                chk("reg_wr_en",   32'(reg_wr_en),      32'(mon_e.wen));
                chk("addr_err",    32'(addr_err),       32'(mon_e.aerr));
                chk("bus_err",     32'(bus_err),        32'(mon_e.berr));
            end
        end else if (addr_err || bus_err) begin
            checks++;
            failures++;
            $display("FAIL stray_err actual=%b%b required=00 cycle=%0d", addr_err, bus_err, cyc);
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r, input logic wen, output int acc);
        ex_valid      = 1'b1;
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_funct3     = f3;
        ex_alu_result = a;
        ex_store_data = d;
        ex_rd         = r;
        ex_reg_wr_en  = wen;
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic alu_op(input logic [31:0] a, input logic [4:0] r, input logic wen);
        int acc;
        issue(1'b0, 1'b0, 3'b000, a, 32'h0, r, wen, acc);
        sb.push_back('{wb_data: a, nwm: 1'b0, mem_data: model_data, f3: 3'b000,
                       idx: a[1:0], rd: r, wen: wen, aerr: 1'b0, berr: 1'b0, at: acc});
    endtask

    task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] r, input logic wen,
                          input int waits, input logic [31:0] rdata,
                          input logic [3:0] strb, input logic [31:0] wdata);
        int acc;
        issue(ld, !ld, f3, a, d, r, wen, acc);
        ex_valid = 1'b0;
        if (ld) model_data = rdata;
        sb.push_back('{wb_data: a, nwm: ld, mem_data: model_data, f3: f3,
                       idx: a[1:0], rd: r, wen: (ld ? wen : 1'b0), aerr: 1'b0,
                       berr: 1'b0, at: acc + 1 + waits});
        for (int k = 0; k <= waits; k++) begin
            bus.dmem_rdata = ~rdata;
            if (k == waits) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = rdata;
            end
            @(negedge clk);
            chk("req",   32'(bus.dmem_req),   32'h1);
            chk("we",    32'(bus.dmem_we),    32'(!ld));
            chk("addr",  bus.dmem_addr,       {a[31:2], 2'b00});
            chk("wstrb", 32'(bus.dmem_wstrb), 32'(strb));
            if (!ld) chk("wdata", bus.dmem_wdata, wdata);
            chk("ready_busy", 32'(ready), 32'h0);
            @(posedge clk);
            #1;
            bus.dmem_ack = 1'b0;
        end
        @(negedge clk);
        chk("req_drop",   32'(bus.dmem_req), 32'h0);
        chk("ready_back", 32'(ready),        32'h1);
    endtask

    task automatic err_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] r);
        int acc;
        issue(ld, !ld, f3, a, 32'h12345678, r, 1'b1, acc);
        ex_valid = 1'b0;
        sb.push_back('{wb_data: a, nwm: 1'b0, mem_data: model_data, f3: f3,
                       idx: a[1:0], rd: r, wen: 1'b0, aerr: 1'b1, berr: 1'b0, at: acc});
        @(negedge clk);
        chk("err_no_req", 32'(bus.dmem_req), 32'h0);
        chk("err_ready",  32'(ready),        32'h1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"},      32'(bus.dmem_req),    32'h0);
        chk({tag, "_we"},       32'(bus.dmem_we),     32'h0);
        chk({tag, "_addr"},     bus.dmem_addr,        32'h0);
        chk({tag, "_wstrb"},    32'(bus.dmem_wstrb),  32'h0);
        chk({tag, "_wdata"},    bus.dmem_wdata,       32'h0);
        chk({tag, "_wb_valid"}, 32'(wb_valid),        32'h0);
        chk({tag, "_wb_data"},  wb_reg_wr_data,       32'h0);
        chk({tag, "_nwm"},      32'(no_writing_mem),  32'h0);
        chk({tag, "_mem_data"}, data_mem_data,        32'h0);
        chk({tag, "_funct3"},   32'(funct3),          32'h0);
        chk({tag, "_idx"},      32'(mem_addr_index),  32'h0);
        chk({tag, "_rd"},       32'(rd),              32'h0);
        chk({tag, "_wen"},      32'(reg_wr_en),       32'h0);
        chk({tag, "_aerr"},     32'(addr_err),        32'h0);
        chk({tag, "_berr"},     32'(bus_err),         32'h0);
        chk({tag, "_ready"},    32'(ready),           32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(ready), 32'h1);

        // LB zero-wait, SH upper half, SB with three wait states
        mem_op(1'b1, 3'b000, 32'h0000_1003, 32'h0, 5'd5, 1'b1, 0, 32'h80FF_1234, 4'b0000, 32'h0);
        mem_op(1'b0, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5'd6, 1'b1, 0, 32'h5555_5555, 4'b1100, 32'hBEEF_BEEF);
        mem_op(1'b0, 3'b000, 32'h0000_1005, 32'h0000_00A5, 5'd7, 1'b1, 3, 32'h0, 4'b0010, 32'hA5A5_A5A5);

        // Back-to-back ALU results
        alu_op(32'h0000_0011, 5'd8, 1'b1);
        alu_op(32'h0000_0022, 5'd9, 1'b1);
        ex_valid = 1'b0;
        @(negedge clk);

        // More load/store widths
        mem_op(1'b1, 3'b001, 32'h0000_1006, 32'h0, 5'd10, 1'b1, 1, 32'hCAFE_F00D, 4'b0000, 32'h0);
        mem_op(1'b1, 3'b100, 32'h0000_1001, 32'h0, 5'd11, 1'b0, 0, 32'h0000_00FE, 4'b0000, 32'h0);
        mem_op(1'b0, 3'b010, 32'h0000_100C, 32'h0BAD_F00D, 5'd12, 1'b1, 2, 32'h0, 4'b1111, 32'h0BAD_F00D);

        // Illegal accesses: misaligned LW/SH, bad load and store width codes
        err_op(1'b1, 3'b010, 32'h0000_0006, 5'd13);
        err_op(1'b0, 3'b001, 32'h0000_2001, 5'd14);
        err_op(1'b1, 3'b011, 32'h0000_1000, 5'd15);
        err_op(1'b0, 3'b100, 32'h0000_1000, 5'd16);

        // Timeout: LW with no ack keeps req high exactly 16 cycles
        issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd17, 1'b1, acc);
        ex_valid = 1'b0;
        sb.push_back('{wb_data: 32'h0000_4000, nwm: 1'b0, mem_data: model_data, f3: 3'b010,
                       idx: 2'b00, rd: 5'd17, wen: 1'b0, aerr: 1'b0, berr: 1'b1, at: acc + 16});
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("to_req_high", 32'(bus.dmem_req), 32'h1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("to_req_low", 32'(bus.dmem_req), 32'h0);
        chk("to_ready",   32'(ready),        32'h1);

        // Reset mid-access abandons the request; a later ack is ignored
        issue(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd18, 1'b1, acc);
        ex_valid = 1'b0;
        @(negedge clk);
        chk("mid_req", 32'(bus.dmem_req), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_data = 32'h0;
        @(negedge clk);
        check_zero("midrst");
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_wb",   32'(wb_valid),    32'h0);
        chk("late_ack_req",  32'(bus.dmem_req), 32'h0);
        chk("late_ack_data", data_mem_data,     32'h0);

        // Normal operation resumes after reset
        alu_op(32'h0000_0033, 5'd19, 1'b0);
        ex_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
